gmii_fcs_crc32_byte: RTL and testbench

//  Byte-serial Ethernet FCS (CRC-32, IEEE 802.3) engine for the GMII traffic generator TX path.

---
 rtl/gmii_fcs_crc32_byte_pkg.sv | 34 +++
 rtl/gmii_fcs_crc32_byte_if.sv | 19 +
 rtl/gmii_fcs_crc32_byte.sv | 61 ++++++
 tb/tb_gmii_fcs_crc32_byte.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/gmii_fcs_crc32_byte_pkg.sv
// Shared CRC-32 (IEEE 802.3) constants and helpers for the GMII TX FCS
// engine and the future RX checker.
//   CRC32_POLY    : generator polynomial, normal (MSB-first) form
//   CRC32_INIT    : register preset at the start of every frame
//   CRC32_RESIDUE : crc_reg after folding data plus its own FCS
//   bitrev8       : reverse the bit order of one byte
//   crc32_next8   : fold one MSB-first byte into a non-reflected CRC register
package gmii_fcs_crc32_byte_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Eight serial LFSR steps unrolled into one combinational stage.
  function automatic logic [31:0] crc32_next8(input logic [31:0] c_in,
                                              input logic [7:0]  b,
                                              input logic [31:0] poly);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ b[7-i];
      c  = {c[30:0], 1'b0} ^ (fb ? poly : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/gmii_fcs_crc32_byte_if.sv
// Byte-stream bus between the GMII TX generator and the FCS engine.
//   d       : frame byte, bit0 first on the wire
//   calc    : 1 = fold d, 0 = unload FCS bytes
//   init    : synchronous re-initialise
//   d_valid : qualifies calc/unload for this cycle
//   crc_reg : running CRC register (non-reflected, not complemented)
//   crc     : registered FCS byte for gmii_d
// master = generator side, slave = CRC engine side.
interface gmii_fcs_crc32_byte_if;
  logic [7:0]  d;
  logic        calc;
  logic        init;
  logic        d_valid;
  logic [31:0] crc_reg;
  logic [7:0]  crc;

  modport master (output d, calc, init, d_valid, input  crc_reg, crc);
  modport slave  (input  d, calc, init, d_valid, output crc_reg, crc);
endinterface

// File: rtl/gmii_fcs_crc32_byte.sv
// Byte-serial Ethernet FCS (CRC-32) engine for the GMII TX path.
// Folds one frame byte per enabled cycle, then unloads the four FCS bytes
// one per cycle in wire order (byte0 is ready the cycle after the last fold).
// Ports:
//   clk   : single clock, all state on posedge
//   reset : asynchronous active-high reset
//   bus   : slave side of gmii_fcs_crc32_byte_if (d/calc/init/d_valid in,
//           crc_reg/crc out; both outputs come straight from registers)
module gmii_fcs_crc32_byte
  import gmii_fcs_crc32_byte_pkg::*;
#(
  parameter logic [31:0] CRC_INIT = CRC32_INIT,
  parameter logic [31:0] CRC_POLY = CRC32_POLY
) (
  input  logic                        clk,
  input  logic                        reset,
  gmii_fcs_crc32_byte_if.slave        bus
);

  logic [31:0] crc_reg_q, crc_reg_d;
  logic [7:0]  crc_q, crc_d;
  logic [31:0] next_crc;

  // Wire bit order is LSB first, so the byte is reversed before entering the
  // MSB-first LFSR.
  assign next_crc = crc32_next8(crc_reg_q, bitrev8(bus.d), CRC_POLY);

  always_comb begin
    crc_reg_d = crc_reg_q;
    crc_d     = crc_q;
    if (bus.d_valid) begin
      if (bus.calc) begin
        crc_reg_d = next_crc;
        crc_d     = ~bitrev8(next_crc[31:24]);
      end else begin
        // Unload: the byte behind the one already presented moves to the top;
        // shifting in 1s makes surplus unload cycles emit 8'h00.
        crc_reg_d = {crc_reg_q[23:0], 8'hFF};
        crc_d     = ~bitrev8(crc_reg_q[23:16]);
      end
    end
  end

  // crc = ~bitrev8(8'hFF) = 8'h00 in the initialised state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_reg_q <= CRC_INIT;
      crc_q     <= ~bitrev8(CRC_INIT[31:24]);
    end else if (bus.init) begin
      crc_reg_q <= CRC_INIT;
      crc_q     <= ~bitrev8(CRC_INIT[31:24]);
    end else begin
      crc_reg_q <= crc_reg_d;
      crc_q     <= crc_d;
    end
  end

  assign bus.crc_reg = crc_reg_q;
  assign bus.crc     = crc_q;

endmodule

// File: tb/tb_gmii_fcs_crc32_byte.sv
module tb_gmii_fcs_crc32_byte;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  gmii_fcs_crc32_byte_if bus_if ();

  gmii_fcs_crc32_byte dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model: reflected (LSB-first, zlib-style) CRC-32 state. The
  // non-reflected crc_reg is its bit mirror.
  logic [31:0] m_reg;
  logic [7:0]  m_crc;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic logic [31:0] refl_update(input logic [31:0] r_in, input logic [7:0] b);
    logic [31:0] r;
    r = r_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ({1'b0, r[31:1]} ^ 32'hEDB8_8320) : {1'b0, r[31:1]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, update model, sample 1ns after posedge.
  task automatic cyc(input logic [7:0] dd, input logic c, input logic i, input logic v,
                     input logic do_chk);
    logic [31:0] r;
    @(negedge clk);
    bus_if.d = dd; bus_if.calc = c; bus_if.init = i; bus_if.d_valid = v;
    @(posedge clk);
    #1;
    if (i) begin
      m_reg = 32'hFFFF_FFFF;
      m_crc = 8'h00;
    end else if (v) begin
      if (c) begin
        r     = refl_update(bitrev32(m_reg), dd);
        m_reg = bitrev32(r);
        m_crc = ~r[7:0];
      end else begin
        r     = ~bitrev32(m_reg);
        m_crc = r[15:8];
        m_reg = {m_reg[23:0], 8'hFF};
      end
    end
    if (do_chk) begin
      chk("crc_reg", bus_if.crc_reg, m_reg);
      chk("crc", {24'h0, bus_if.crc}, {24'h0, m_crc});
    end
  endtask

  task automatic check_fcs_123(input string tag);
    chk({tag, "_b0"}, {24'h0, bus_if.crc}, 32'h26);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk({tag, "_b1"}, {24'h0, bus_if.crc}, 32'h39);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk({tag, "_b2"}, {24'h0, bus_if.crc}, 32'hF4);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk({tag, "_b3"}, {24'h0, bus_if.crc}, 32'hCB);
  endtask

  initial begin
    logic [7:0]  frame [64];
    logic [31:0] zr, fcs, hold;

    bus_if.d = 8'h00; bus_if.calc = 1'b0; bus_if.init = 1'b1; bus_if.d_valid = 1'b0;
    m_reg = 32'hFFFF_FFFF; m_crc = 8'h00;

    // Reset and idle with init held
    reset = 1'b1;
    #1;
    chk("rst_crc_reg", bus_if.crc_reg, 32'hFFFF_FFFF);
    chk("rst_crc", {24'h0, bus_if.crc}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) cyc(8'hA5 + 8'(k), k[0], 1'b1, 1'b1, 1'b1);
    chk("idle_init_reg", bus_if.crc_reg, 32'hFFFF_FFFF);

    // "123456789" -> CBF43926
    for (int k = 0; k < 9; k++) cyc(8'h31 + 8'(k), 1'b1, 1'b0, 1'b1, 1'b1);
    check_fcs_123("check");
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("extra_unload", {24'h0, bus_if.crc}, 32'h00);

    // Minimum frame of zeros plus its FCS leaves the receive residue
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 60; k++) cyc(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    fcs = ~bitrev32(m_reg);
    for (int k = 0; k < 4; k++) cyc(fcs[8*k +: 8], 1'b1, 1'b0, 1'b1, 1'b1);
    chk("residue", bus_if.crc_reg, 32'hC704_DD7B);

    // d_valid gaps, random calc during gaps
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      cyc(8'h31 + 8'(k), 1'b1, 1'b0, 1'b1, 1'b1);
      hold = bus_if.crc_reg;
      repeat (1 + (k % 3)) cyc(8'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1);
      chk("gap_hold", bus_if.crc_reg, hold);
    end
    check_fcs_123("gaps");

    // Init after 5 bytes, then full refeed
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) cyc(8'h31 + 8'(k), 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 9; k++) cyc(8'h31 + 8'(k), 1'b1, 1'b0, 1'b1, 1'b1);
    chk("reinit_b0", {24'h0, bus_if.crc}, 32'h26);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("reinit_b1", {24'h0, bus_if.crc}, 32'h39);

    // Asynchronous reset mid-unload
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_rst_crc", {24'h0, bus_if.crc}, 32'h00);
    chk("async_rst_reg", bus_if.crc_reg, 32'hFFFF_FFFF);
    bus_if.init = 1'b1;
    m_reg = 32'hFFFF_FFFF; m_crc = 8'h00;
    @(negedge clk);
    reset = 1'b0;

    // Generator-timed random 64-byte frames
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 7; k++) frame[k] = 8'h55;
      frame[7] = 8'hD5;
      for (int k = 8; k < 60; k++) frame[k] = 8'($urandom);
      zr = 32'hFFFF_FFFF;
      for (int k = 8; k < 60; k++) zr = refl_update(zr, frame[k]);
      zr = ~zr;
      for (int k = 0; k < 8; k++) cyc(frame[k], 1'b0, 1'b1, 1'b1, 1'b1);
      for (int k = 8; k < 60; k++) cyc(frame[k], 1'b1, 1'b0, 1'b1, 1'b1);
      chk("gen_fcs0", {24'h0, bus_if.crc}, {24'h0, zr[7:0]});
      for (int k = 1; k < 4; k++) begin
        cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("gen_fcs", {24'h0, bus_if.crc}, {24'h0, zr[8*k +: 8]});
      end
      cyc(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
